// File: rtl/hamming_stripe_writer.sv
// hamming_stripe_writer: Hamming-encodes a host byte and read-modify-writes one drive of a 2+1 stripe.
module hamming_stripe_writer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_req,
  input  logic [7:0]  wr_data,
  input  logic [7:0]  wr_addr,
  input  logic        wr_drive,
  output logic        wr_ready,
  output logic        rd_en,
  output logic [7:0]  rd_addr,
  input  logic        rd_valid,
  input  logic [11:0] D0_rd,
  input  logic [11:0] D1_rd,
  input  logic [11:0] P_rd,
  output logic        st_wr_en,
  output logic [7:0]  st_wr_addr,
  output logic [11:0] D0_wr,
  output logic [11:0] D1_wr,
  output logic [11:0] P_wr,
  output logic        done,
  output logic        err_timeout
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WR    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ABORT = 3'd5;
  logic [2:0]  state_q, state_d;
  logic [7:0]  addr_q, addr_d, cnt_q, cnt_d;
  logic        drive_q, drive_d;
  logic [11:0] cw_q, cw_d, enc, d0_q, d0_d, d1_q, d1_d, p_q, p_d;
  always_comb begin
    enc = {wr_data[7:4], 1'b0, wr_data[3:1], 1'b0, wr_data[0], 2'b00};
    enc[0] = enc[2] ^ enc[4] ^ enc[6] ^ enc[8] ^ enc[10];
    enc[1] = enc[2] ^ enc[5] ^ enc[6] ^ enc[9] ^ enc[10];
    enc[3] = enc[4] ^ enc[5] ^ enc[6] ^ enc[11];
    enc[7] = enc[8] ^ enc[9] ^ enc[10] ^ enc[11];
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drive_d = drive_q;
    cw_d    = cw_q;
    cnt_d   = cnt_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: if (wr_req) begin
        state_d = S_RD;
        addr_d  = wr_addr;
        drive_d = wr_drive;
        cw_d    = enc;
      end
      S_RD: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: if (rd_valid) begin
        state_d = S_WR;
        d0_d    = drive_q ? D0_rd : cw_q;
        d1_d    = drive_q ? cw_q : D1_rd;
        p_d     = P_rd ^ (drive_q ? D1_rd : D0_rd) ^ cw_q;
      end else begin
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_q == 8'(TIMEOUT - 1)) ? S_ABORT : S_WAIT;
      end
      S_WR:    state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      drive_q <= 1'b0;
      cw_q    <= '0;
      cnt_q   <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drive_q <= drive_d;
      cw_q    <= cw_d;
      cnt_q   <= cnt_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      p_q     <= p_d;
    end
  end
  // Outputs decode straight from state so an asynchronous reset clears them at once.
  assign wr_ready    = state_q == S_IDLE;
  assign rd_en       = state_q == S_RD;
  assign st_wr_en    = state_q == S_WR;
  assign done        = state_q == S_DONE;
  assign err_timeout = state_q == S_ABORT;
  assign rd_addr     = rd_en ? addr_q : '0;
  assign st_wr_addr  = st_wr_en ? addr_q : '0;
  assign D0_wr       = st_wr_en ? d0_q : '0;
  assign D1_wr       = st_wr_en ? d1_q : '0;
  assign P_wr        = st_wr_en ? p_q : '0;
endmodule
